// File: rtl/regfile_param_if.sv
// Connects decode/control to the register file.
// Carries the write port, both read ports, the scoreboard and the clear-sweep control.
interface regfile_param_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
);
   logic              iWrEn;
   logic [ADDR_W-1:0] iWrAddr;
   logic [DATA_W-1:0] iWrData;
   logic [ADDR_W-1:0] iRdAddrA;
   logic [ADDR_W-1:0] iRdAddrB;
   logic [DATA_W-1:0] oRdDataA;
   logic [DATA_W-1:0] oRdDataB;
   logic              iRsvEn;
   logic [ADDR_W-1:0] iRsvAddr;
   logic              oBusyA;
   logic              oBusyB;
   logic              oRsvErr;
   logic              iClrStart;
   logic              oClrBusy;
   logic              oClrDone;
   logic              oWrDrop;

   modport master (
      output iWrEn, iWrAddr, iWrData, iRdAddrA, iRdAddrB, iRsvEn, iRsvAddr, iClrStart,
      input  oRdDataA, oRdDataB, oBusyA, oBusyB, oRsvErr, oClrBusy, oClrDone, oWrDrop
   );

   modport slave (
      input  iWrEn, iWrAddr, iWrData, iRdAddrA, iRdAddrB, iRsvEn, iRsvAddr, iClrStart,
      output oRdDataA, oRdDataB, oBusyA, oBusyB, oRsvErr, oClrBusy, oClrDone, oWrDrop
   );
endinterface

// File: rtl/regfile_param.sv
// Parametrised register file: one write port, two combinational read ports with optional bypass,
// optional hard-wired zero R0, per-register busy bits and a one-register-per-cycle clear sweep.
module regfile_param #(
   parameter int DATA_W   = 16,
   parameter int NUM_REGS = 8,
   parameter bit BYPASS   = 1'b1,
   parameter bit ZERO_R0  = 1'b0
) (
   input  logic           iClk,
   input  logic           iRst,
   regfile_param_if.slave bus
);
   localparam int                ADDR_W   = $clog2(NUM_REGS);
   localparam logic [ADDR_W:0]   NUM_L    = (ADDR_W+1)'(NUM_REGS);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_DONE} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
   logic              wr_drop_q, wr_drop_d;
   logic              rsv_err_q, rsv_err_d;
   logic              clr_busy, clr_done;

   logic [DATA_W-1:0]   rf_q [NUM_REGS];
   logic [NUM_REGS-1:0] busy_q;

   logic idle;
   logic wr_in_range, wr_ok, rsv_ok;

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return ({1'b0, a} < NUM_L);
   endfunction

   function automatic logic writable(input logic [ADDR_W-1:0] a);
      return in_range(a) && !(ZERO_R0 && (a == '0));
   endfunction

   assign idle        = (state_q == ST_IDLE);
   assign wr_in_range = in_range(bus.iWrAddr);
   // A write to a hard-wired R0 is silently ignored, never reported as dropped.
   assign wr_ok       = bus.iWrEn && idle && writable(bus.iWrAddr);
   assign rsv_ok      = bus.iRsvEn && idle && writable(bus.iRsvAddr);
   assign wr_drop_d   = bus.iWrEn && (!idle || !wr_in_range);
   assign rsv_err_d   = rsv_ok && busy_q[bus.iRsvAddr]
                        && !(wr_ok && (bus.iWrAddr == bus.iRsvAddr));

   // Storage: each register and its busy bit own their next-state logic.
   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);
      logic [DATA_W-1:0] data_q, data_d;
      logic              bit_q, bit_d;

      always_comb begin
         data_d = data_q;
         bit_d  = bit_q;
         if (state_q == ST_CLEAR && clr_idx_q == IDX) begin
            data_d = '0;
            bit_d  = 1'b0;
         end else begin
            if (wr_ok && bus.iWrAddr == IDX) begin
               data_d = bus.iWrData;
               bit_d  = 1'b0;
            end
            if (rsv_ok && bus.iRsvAddr == IDX) begin
               bit_d = 1'b1;
            end
         end
      end

      always_ff @(posedge iClk) begin
         if (iRst) begin
            data_q <= '0;
            bit_q  <= 1'b0;
         end else begin
            data_q <= data_d;
            bit_q  <= bit_d;
         end
      end

      assign rf_q[gi]   = data_q;
      assign busy_q[gi] = bit_q;
   end

   // Read ports: index 0 is port A, index 1 is port B.
   for (genvar gi = 0; gi < 2; gi++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              busy;

      assign addr = (gi == 0) ? bus.iRdAddrA : bus.iRdAddrB;

      always_comb begin
         data = '0;
         busy = 1'b0;
         if (in_range(addr)) begin
            data = rf_q[addr];
            busy = busy_q[addr];
         end
         if (BYPASS && wr_ok && bus.iWrAddr == addr) begin
            data = bus.iWrData;
         end
      end
   end

   assign bus.oRdDataA = g_rd[0].data;
   assign bus.oRdDataB = g_rd[1].data;
   assign bus.oBusyA   = g_rd[0].busy;
   assign bus.oBusyB   = g_rd[1].busy;

   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      clr_busy  = 1'b0;
      clr_done  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.iClrStart) begin
               state_d   = ST_CLEAR;
               clr_idx_d = '0;
            end
         end
         ST_CLEAR: begin
            clr_busy = 1'b1;
            if (clr_idx_q == LAST_IDX) begin
               state_d = ST_DONE;
            end else begin
               clr_idx_d = clr_idx_q + 1'b1;
            end
         end
         ST_DONE: begin
            clr_busy = 1'b1;
            clr_done = 1'b1;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_q   <= ST_IDLE;
         clr_idx_q <= '0;
         wr_drop_q <= 1'b0;
         rsv_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         clr_idx_q <= clr_idx_d;
         wr_drop_q <= wr_drop_d;
         rsv_err_q <= rsv_err_d;
      end
   end

   assign bus.oClrBusy = clr_busy;
   assign bus.oClrDone = clr_done;
   assign bus.oWrDrop  = wr_drop_q;
   assign bus.oRsvErr  = rsv_err_q;
endmodule
